cam_capture_ctrl: RTL and testbench
===================================

// Module: cam_capture_ctrl
// PURPOSE
//  Sequencer between the LM32 bus and the camera capture block (cam_read). The CPU writes a
//  start/mode command; this block pulses cam_init, tracks the frame via vsync, judges the
//  capture from cam_done at frame end, retries failed or timed-out frames, counts successful
//  frames, exposes status, raises an interrupt, and flags frame-buffer ownership.
// PARAMETERS
//  MAX_RETRY  3         reset value of CFG.max_retry (4 bits)
//  TO_W       24        width of the per-attempt timeout counter
//  TIMEOUT    24'h7FFFFF pclk cycles allowed per attempt, from cam_init to judgement
// PORTS
//  pclk       in   1   single clock, shared with cam_read
//  rst        in   1   asynchronous reset, active-low
//  bus_stb    in   1   bus request strobe; held until bus_ack
//  bus_we     in   1   1 = write, 0 = read
//  bus_addr   in   2   register index
//  bus_wdata  in   32  write data
//  bus_rdata  out  32  read data, valid while bus_ack is high
//  bus_ack    out  1   one-cycle acknowledge
//  vsync      in   1   camera vsync, same net as cam_read.vsync
//  cam_done   in   1   cam_read.done
//  cam_init   out  1   start pulse to cam_read.init
//  buf_cam    out  1   1 = frame buffer owned by camera (readers must not use it)
//  irq        out  1   level interrupt: pending & irq_en
// BEHAVIOUR
//  Reset: cam_init=0, buf_cam=0, irq=0, bus_ack=0, bus_rdata=0, state IDLE, all counters 0,
//  cont=0, irq_en=0, max_retry=MAX_RETRY.
//  Bus: bus_ack=1 in the cycle after bus_stb=1 & bus_ack=0, so the strobe is acknowledged
//  one cycle later. bus_ack is a single pulse. Writes take effect on the ack cycle. Read data
//  is registered at the same time.
//  Registers:
//   0 CTRL   W: b0 start (write 1 to start), b1 cont, b2 abort (write 1). R: b1 cont.
//   1 STATUS R: b0 busy, b1 done, b2 fail, b3 last_timeout, [15:8] frame_cnt,
//            [19:16] retry_cnt.
//   2 CFG    R/W: [3:0] max_retry.
//   3 IRQ    R/W: b0 irq_en. R: b1 pending. W: b1=1 clears pending.
//  FSM:
//   IDLE: start -> ARM. Entering ARM clears done, fail, last_timeout and retry_cnt.
//         Start while not IDLE is ignored.
//   ARM:  cam_init=1 for exactly 1 cycle, clears the timeout counter and the fall_seen flag.
//         Next state is WAIT.
//   WAIT: a vsync falling edge sets fall_seen. A vsync rising edge with fall_seen=1 goes to
//         EVAL. When the timeout counter reaches TIMEOUT, set last_timeout and go to JUDGE_FAIL.
//   EVAL: one cycle after the rising edge, sample cam_done.
//         cam_done=1: frame_cnt+1 (wraps 255->0), then go to ARM if cont=1, else set done and
//         pending and go to IDLE.
//         cam_done=0: go to JUDGE_FAIL.
//   JUDGE_FAIL: retry_cnt<max_retry -> retry_cnt+1, go to ARM. Otherwise set fail and pending,
//         go to IDLE.
//  - busy=1 and buf_cam=1 in ARM, WAIT, EVAL and JUDGE_FAIL; both are 0 in IDLE.
//  - Abort: any state goes to IDLE on the ack cycle. cam_init is forced to 0. done and fail
//    are unchanged and pending is not set. If abort and start are written together, abort wins.
//  - Clearing cont mid-capture: the current frame finishes, then the FSM returns to IDLE
//    with done=1.
//  - max_retry=0: a single attempt, no retries.
//  - Edge detection uses a registered copy of vsync, reset to 1.
//  - If a pending-set event and a clear write hit the same cycle, set wins.
//  - Reset asserted mid-capture: everything returns to reset values immediately.
// TESTING
//  T1 write CTRL=1; give one vsync fall then rise with cam_done=1 ->
//     one cam_init pulse, busy 1->0, STATUS.done=1, frame_cnt=1, irq=1 (with irq_en=1).
//  T2 max_retry=2; cam_done=0 on every frame -> exactly 3 cam_init pulses,
//     then fail=1, retry_cnt=2, busy=0.
//  T3 TIMEOUT=100 (sim override); no vsync activity -> last_timeout=1, retries run,
//     then fail=1 after 1+max_retry attempts.
//  T4 cont=1, 300 good frames, then clear cont -> frame_cnt=300 mod 256=44, ends in IDLE with done=1.
//  T5 abort during WAIT -> IDLE next cycle, buf_cam=0, irq unchanged.
//     CTRL=0b101 written in IDLE -> stays IDLE.
//  T6 rst low during WAIT -> all outputs at reset values in the same cycle.
//     A start write while busy does not produce a second cam_init.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
//   Sequences frame capture between the CPU bus and the camera capture block.
//   A CPU write starts a capture. The block pulses cam_init and follows the
//   frame through vsync. At frame end it judges the result from cam_done.
//   Failed or timed-out attempts are retried up to max_retry times. Good frames
//   are counted. Status is readable over the bus. A level interrupt is raised
//   when a capture finishes. buf_cam tells readers whether the frame buffer is
//   currently owned by the camera.
//
// Ports
//   pclk       : single clock, shared with the capture block
//   rst        : asynchronous reset, active-low
//   bus_stb    : request strobe, held until bus_ack
//   bus_we     : 1 = write, 0 = read
//   bus_addr   : register index (0 CTRL, 1 STATUS, 2 CFG, 3 IRQ)
//   bus_wdata  : write data
//   bus_rdata  : read data, valid while bus_ack is high
//   bus_ack    : one-cycle acknowledge
//   vsync      : camera vsync
//   cam_done   : capture-complete flag from the capture block
//   cam_init   : one-cycle start pulse to the capture block
//   buf_cam    : 1 = frame buffer owned by the camera
//   irq        : level interrupt, pending & irq_en
//   dbg_state  : current FSM state (0 IDLE, 1 ARM, 2 WAIT, 3 EVAL, 4 JUDGE_FAIL)
// -----------------------------------------------------------------------------
module cam_capture_ctrl #(
  parameter logic [3:0]      MAX_RETRY = 4'd3,
  parameter int unsigned     TO_W      = 24,
  parameter logic [TO_W-1:0] TIMEOUT   = TO_W'(24'h7FFFFF)
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic        vsync,
  input  logic        cam_done,
  output logic        cam_init,
  output logic        buf_cam,
  output logic        irq,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_EVAL = 3'd3,
    S_FAIL = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             vsync_q, vsync_d;
  logic             fall_seen_q, fall_seen_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             cont_q, cont_d;
  logic             irq_en_q, irq_en_d;
  logic             pending_q, pending_d;
  logic [3:0]       max_retry_q, max_retry_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             last_to_q, last_to_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;

  logic             busy;

  // Bus handshake: a transfer is accepted on the clock edge where bus_stb is
  // high and bus_ack is low. That same edge commits the write, captures the
  // read data and raises bus_ack for one cycle. The master drops bus_stb
  // after it sees bus_ack.
  logic acc, wr, ctrl_wr, start_cmd, abort_cmd;
  assign acc       = bus_stb & ~ack_q;
  assign wr        = acc & bus_we;
  assign ctrl_wr   = wr & (bus_addr == 2'd0);
  assign start_cmd = ctrl_wr & bus_wdata[0];
  assign abort_cmd = ctrl_wr & bus_wdata[2];

  logic vs_fall, vs_rise, to_hit, retry_ok;
  assign vs_fall  = vsync_q & ~vsync;
  assign vs_rise  = ~vsync_q & vsync;
  assign to_hit   = (to_cnt_q == TIMEOUT);
  assign retry_ok = (retry_cnt_q < max_retry_q);

  // State register and all datapath flops.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      vsync_q     <= 1'b1;
      fall_seen_q <= 1'b0;
      to_cnt_q    <= '0;
      cont_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      pending_q   <= 1'b0;
      max_retry_q <= MAX_RETRY;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      last_to_q   <= 1'b0;
      frame_cnt_q <= '0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      vsync_q     <= vsync_d;
      fall_seen_q <= fall_seen_d;
      to_cnt_q    <= to_cnt_d;
      cont_q      <= cont_d;
      irq_en_q    <= irq_en_d;
      pending_q   <= pending_d;
      max_retry_q <= max_retry_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      last_to_q   <= last_to_d;
      frame_cnt_q <= frame_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // Next-state logic. Abort overrides every transition, including a start
  // written in the same word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_cmd) state_d = S_ARM;
      S_ARM:  state_d = S_WAIT;
      S_WAIT: begin
        if (vs_rise && fall_seen_q) state_d = S_EVAL;
        else if (to_hit)            state_d = S_FAIL;
      end
      S_EVAL: begin
        if (cam_done) state_d = cont_q ? S_ARM : S_IDLE;
        else          state_d = S_FAIL;
      end
      S_FAIL: state_d = retry_ok ? S_ARM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_cmd) state_d = S_IDLE;
  end

  // Datapath next values. An abort suppresses every status update of the
  // cycle, so done/fail/pending/counters keep their prior values.
  always_comb begin
    logic set_pending;
    set_pending = 1'b0;
    ack_d       = bus_stb & ~ack_q;
    rdata_d     = rdata_q;
    vsync_d     = vsync;
    fall_seen_d = fall_seen_q;
    to_cnt_d    = to_cnt_q;
    cont_d      = cont_q;
    irq_en_d    = irq_en_q;
    pending_d   = pending_q;
    max_retry_d = max_retry_q;
    done_d      = done_q;
    fail_d      = fail_q;
    last_to_d   = last_to_q;
    frame_cnt_d = frame_cnt_q;
    retry_cnt_d = retry_cnt_q;

    case (state_q)
      S_ARM: begin
        fall_seen_d = 1'b0;
        to_cnt_d    = '0;
      end
      S_WAIT: begin
        if (vs_fall) fall_seen_d = 1'b1;
        if (!to_hit) to_cnt_d = to_cnt_q + TO_W'(1);
      end
      default: ;
    endcase

    if (!abort_cmd) begin
      case (state_q)
        S_IDLE: begin
          if (start_cmd) begin
            done_d      = 1'b0;
            fail_d      = 1'b0;
            last_to_d   = 1'b0;
            retry_cnt_d = '0;
          end
        end
        S_WAIT: begin
          if (!(vs_rise && fall_seen_q) && to_hit) last_to_d = 1'b1;
        end
        S_EVAL: begin
          if (cam_done) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (!cont_q) begin
              done_d      = 1'b1;
              set_pending = 1'b1;
            end
          end
        end
        S_FAIL: begin
          if (retry_ok) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
          end else begin
            fail_d      = 1'b1;
            set_pending = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (wr) begin
      case (bus_addr)
        2'd0: cont_d = bus_wdata[1];
        2'd2: max_retry_d = bus_wdata[3:0];
        2'd3: begin
          irq_en_d = bus_wdata[0];
          if (bus_wdata[1]) pending_d = 1'b0;
        end
        default: ;
      endcase
    end
    // A completion in the same cycle as a clear write leaves pending set.
    if (set_pending) pending_d = 1'b1;

    if (acc) begin
      case (bus_addr)
        2'd0: rdata_d = {30'd0, cont_q, 1'b0};
        2'd1: rdata_d = {12'd0, retry_cnt_q, frame_cnt_q, 4'd0,
                         last_to_q, fail_q, done_q, busy};
        2'd2: rdata_d = {28'd0, max_retry_q};
        default: rdata_d = {30'd0, pending_q, irq_en_q};
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    cam_init  = (state_q == S_ARM);
    buf_cam   = busy;
    irq       = pending_q & irq_en_q;
    bus_ack   = ack_q;
    bus_rdata = rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;

  logic        pclk;
  logic        rst;
  logic        bus_stb;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        vsync;
  logic        cam_done;
  logic        cam_init;
  logic        buf_cam;
  logic        irq;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int init_cnt = 0;
  int exp_frames = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic [31:0] exp;

  cam_capture_ctrl #(.MAX_RETRY(4'd3), .TO_W(24), .TIMEOUT(24'd100)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .vsync     (vsync),
    .cam_done  (cam_done),
    .cam_init  (cam_init),
    .buf_cam   (buf_cam),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) if (cam_init === 1'b1) init_cnt++;

  // Expected STATUS word from the bench's own model values.
  function automatic logic [31:0] status_word(input logic busy, input logic done,
      input logic fail, input logic lt, input int frames, input int retry);
    logic [7:0] f;
    logic [3:0] r;
    f = 8'(frames % 256);
    r = 4'(retry);
    return {12'd0, r, f, 4'd0, lt, fail, done, busy};
  endfunction

  // Driver tasks
  task automatic bus_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] data);
    bit got;
    got = 0;
    data = 'x;
    @(posedge pclk); #1;
    bus_stb = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      if (bus_ack === 1'b1) begin
        got = 1;
        data = bus_rdata;
        break;
      end
    end
    bus_stb = 1'b0; bus_we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_ack_timeout addr=%0d got no ack want ack within 8 cycles", a);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] unused;
    bus_xfer(1'b1, a, d, unused);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] data);
    bus_xfer(1'b0, a, 32'd0, data);
  endtask

  task automatic give_frame(input logic ok);
    @(posedge pclk); #1;
    vsync = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    vsync = 1'b1;
    cam_done = ok;
    repeat (4) @(posedge pclk);
    #1;
    cam_done = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    checks++;
    if ({cam_init, buf_cam, irq, bus_ack} !== 4'b0000 || bus_rdata !== 32'd0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs got init=%b buf=%b irq=%b ack=%b rdata=%h st=%0d want all 0",
               cam_init, buf_cam, irq, bus_ack, bus_rdata, dbg_state);
    end
    exp_q.push_back(32'd0);
    bus_read(2'd0, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL reset_ctrl got %h want %h", rd, exp); end
    exp_q.push_back(status_word(0, 0, 0, 0, 0, 0));
    bus_read(2'd1, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL reset_status got %h want %h", rd, exp); end
    exp_q.push_back(32'd3);
    bus_read(2'd2, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL reset_cfg got %h want %h", rd, exp); end
    exp_q.push_back(32'd0);
    bus_read(2'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL reset_irq got %h want %h", rd, exp); end
  endtask

  task automatic test_single_frame();
    int n0;
    bus_write(2'd3, 32'd1);
    n0 = init_cnt;
    bus_write(2'd0, 32'd1);
    checks++;
    if (cam_init !== 1'b1 || buf_cam !== 1'b1) begin
      errors++;
      $display("FAIL t1_arm got init=%b buf=%b want 1 1", cam_init, buf_cam);
    end
    give_frame(1'b1);
    exp_frames = exp_frames + 1;
    repeat (2) @(posedge pclk); #1;
    checks++;
    if (init_cnt - n0 !== 1) begin
      errors++; $display("FAIL t1_init_pulses got %0d want 1", init_cnt - n0);
    end
    checks++;
    if (irq !== 1'b1 || buf_cam !== 1'b0) begin
      errors++; $display("FAIL t1_irq_buf got irq=%b buf=%b want 1 0", irq, buf_cam);
    end
    exp_q.push_back(status_word(0, 1, 0, 0, exp_frames, 0));
    bus_read(2'd1, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t1_status got %h want %h", rd, exp); end
    exp_q.push_back(32'd3);
    bus_read(2'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t1_irq_reg got %h want %h", rd, exp); end
    bus_write(2'd3, 32'd3);
    @(posedge pclk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL t1_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_retry();
    int n0;
    bus_write(2'd2, 32'd2);
    n0 = init_cnt;
    bus_write(2'd0, 32'd1);
    for (int f = 0; f < 4; f++) give_frame(1'b0);
    repeat (3) @(posedge pclk); #1;
    checks++;
    if (init_cnt - n0 !== 3) begin
      errors++; $display("FAIL t2_init_pulses got %0d want 3", init_cnt - n0);
    end
    checks++;
    if (buf_cam !== 1'b0 || irq !== 1'b1) begin
      errors++; $display("FAIL t2_end got buf=%b irq=%b want 0 1", buf_cam, irq);
    end
    exp_q.push_back(status_word(0, 0, 1, 0, exp_frames, 2));
    bus_read(2'd1, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t2_status got %h want %h", rd, exp); end
    bus_write(2'd3, 32'd3);
  endtask

  task automatic test_timeout();
    int n0;
    bit idle;
    idle = 0;
    bus_write(2'd2, 32'd1);
    n0 = init_cnt;
    bus_write(2'd0, 32'd1);
    for (int i = 0; i < 1000; i++) begin
      @(negedge pclk);
      if (buf_cam === 1'b0) begin idle = 1; break; end
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL t3_idle_timeout got busy want idle within 1000 cycles"); end
    checks++;
    if (init_cnt - n0 !== 2) begin
      errors++; $display("FAIL t3_init_pulses got %0d want 2", init_cnt - n0);
    end
    exp_q.push_back(status_word(0, 0, 1, 1, exp_frames, 1));
    bus_read(2'd1, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t3_status got %h want %h", rd, exp); end
    bus_write(2'd3, 32'd3);
  endtask

  task automatic test_cont();
    int n0;
    n0 = init_cnt;
    bus_write(2'd0, 32'd3);
    for (int f = 0; f < 299; f++) give_frame(1'b1);
    bus_write(2'd0, 32'd0);
    checks++;
    if (buf_cam !== 1'b1) begin errors++; $display("FAIL t4_still_busy got buf=%b want 1", buf_cam); end
    give_frame(1'b1);
    exp_frames = exp_frames + 300;
    repeat (3) @(posedge pclk); #1;
    checks++;
    if (init_cnt - n0 !== 300 || buf_cam !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL t4_end got pulses=%0d buf=%b irq=%b want 300 0 1", init_cnt - n0, buf_cam, irq);
    end
    exp_q.push_back(status_word(0, 1, 0, 0, exp_frames, 0));
    bus_read(2'd1, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t4_status got %h want %h", rd, exp); end
  endtask

  task automatic test_abort();
    int n0;
    n0 = init_cnt;
    bus_write(2'd0, 32'd1);
    repeat (3) @(posedge pclk); #1;
    checks++;
    if (dbg_state !== 3'd2) begin errors++; $display("FAIL t5_in_wait got %0d want 2", dbg_state); end
    bus_write(2'd0, 32'd4);
    checks++;
    if (dbg_state !== 3'd0 || buf_cam !== 1'b0 || irq !== 1'b1) begin
      errors++; $display("FAIL t5_abort got st=%0d buf=%b irq=%b want 0 0 1", dbg_state, buf_cam, irq);
    end
    exp_q.push_back(status_word(0, 0, 0, 0, exp_frames, 0));
    bus_read(2'd1, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t5_status got %h want %h", rd, exp); end
    bus_write(2'd0, 32'd5);
    repeat (4) @(posedge pclk); #1;
    checks++;
    if (dbg_state !== 3'd0 || init_cnt - n0 !== 1) begin
      errors++; $display("FAIL t5_start_abort got st=%0d pulses=%0d want 0 1", dbg_state, init_cnt - n0);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = init_cnt;
    bus_write(2'd0, 32'd1);
    repeat (2) @(posedge pclk);
    bus_write(2'd0, 32'd1);
    repeat (4) @(posedge pclk); #1;
    checks++;
    if (init_cnt - n0 !== 1 || dbg_state !== 3'd2) begin
      errors++; $display("FAIL t6_start_busy got pulses=%0d st=%0d want 1 2", init_cnt - n0, dbg_state);
    end
    @(posedge pclk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({cam_init, buf_cam, irq, bus_ack} !== 4'b0000 || bus_rdata !== 32'd0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL t6_async_reset got init=%b buf=%b irq=%b ack=%b rdata=%h st=%0d want all 0",
               cam_init, buf_cam, irq, bus_ack, bus_rdata, dbg_state);
    end
    repeat (2) @(posedge pclk); #3;
    rst = 1'b1;
    exp_frames = 0;
    exp_q.push_back(status_word(0, 0, 0, 0, exp_frames, 0));
    bus_read(2'd1, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t6_status got %h want %h", rd, exp); end
    exp_q.push_back(32'd3);
    bus_read(2'd2, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL t6_cfg got %h want %h", rd, exp); end
  endtask

  initial begin
    rst = 1'b0;
    bus_stb = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 32'd0;
    vsync = 1'b1; cam_done = 1'b0;
    repeat (3) @(posedge pclk);
    #3 rst = 1'b1;
    test_reset();
    test_single_frame();
    test_retry();
    test_timeout();
    test_cont();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
